// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath constants, FSM state type and GF(2^8) xtime
package aes_pkg;

  localparam int WORD_SIZE  = 8;
  localparam int ARRAY_SIZE = 16;

  localparam logic [7:0] POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mc_state_e;

  localparam logic MC_FWD = 1'b0;
  localparam logic MC_INV = 1'b1;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// rtl/mix_column_unit.sv - combinational forward/inverse MixColumns on one 32-bit column
// Row 0 is the most significant byte; every coefficient is an xtime chain plus XOR.
module mix_column_unit
  import aes_pkg::*;
(
  input  logic        mode,
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i]  = col_in[(3-i)*8 +: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
    end
  end

  // Row r uses the base coefficient row rotated right by r, i.e. byte (r+k)%4 gets coef k.
  always_comb begin
    col_out = '0;
    for (int r = 0; r < 4; r++) begin
      if (mode == MC_INV) begin
        col_out[(3-r)*8 +: 8] = (x8[r] ^ x4[r] ^ x2[r])
                              ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ a[(r+1)%4])
                              ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ a[(r+2)%4])
                              ^ (x8[(r+3)%4] ^ a[(r+3)%4]);
      end else begin
        col_out[(3-r)*8 +: 8] = x2[r]
                              ^ (x2[(r+1)%4] ^ a[(r+1)%4])
                              ^ a[(r+2)%4]
                              ^ a[(r+3)%4];
      end
    end
  end

endmodule

// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - sequential MixColumns/InvMixColumns engine, COLS_PER_CYCLE columns per clock
// Optional MIXCOL_BYPASS_EN adds a bypass input that passes columns through unchanged.
module mix_columns_seq #(
  parameter int WORD_SIZE      = 8,
  parameter int ARRAY_SIZE     = 16,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            mode,
`ifdef MIXCOL_BYPASS_EN
  input  logic                            bypass,
`endif
  input  logic [WORD_SIZE*ARRAY_SIZE-1:0] state,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WORD_SIZE*ARRAY_SIZE-1:0] state_out,
  output logic                            busy
);

  import aes_pkg::*;

  if (WORD_SIZE != 8 || ARRAY_SIZE != 16) begin : g_bad_size
    $error("mix_columns_seq: only WORD_SIZE=8 and ARRAY_SIZE=16 are supported");
  end
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  mc_state_e    fsm_q, fsm_d;
  logic [127:0] work_q, work_d;
  logic         mode_q, mode_d;
  logic         bypass_q, bypass_d;
  logic [1:0]   col_cnt_q, col_cnt_d;

  logic [1:0]   cidx     [COLS_PER_CYCLE];
  logic [31:0]  unit_in  [COLS_PER_CYCLE];
  logic [31:0]  unit_out [COLS_PER_CYCLE];

  always_comb begin
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      cidx[i]    = col_cnt_q + 2'(i);
      unit_in[i] = work_q[32*(2'd3 - cidx[i]) +: 32];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
    mix_column_unit u_mix (
      .mode    (mode_q),
      .col_in  (unit_in[g]),
      .col_out (unit_out[g])
    );
  end

  always_comb begin
    fsm_d     = fsm_q;
    work_d    = work_q;
    mode_d    = mode_q;
    bypass_d  = bypass_q;
    col_cnt_d = col_cnt_q;
    unique case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          work_d    = state;
          mode_d    = mode;
`ifdef MIXCOL_BYPASS_EN
          bypass_d  = bypass;
`else
          bypass_d  = 1'b0;
`endif
          col_cnt_d = 2'd0;
          fsm_d     = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < COLS_PER_CYCLE; i++) begin
          work_d[32*(2'd3 - cidx[i]) +: 32] = bypass_q ? unit_in[i] : unit_out[i];
        end
        col_cnt_d = col_cnt_q + COL_STEP;
        if (col_cnt_q == LAST_COL) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= IDLE;
      work_q    <= '0;
      mode_q    <= MC_FWD;
      bypass_q  <= 1'b0;
      col_cnt_q <= 2'd0;
    end else begin
      fsm_q     <= fsm_d;
      work_q    <= work_d;
      mode_q    <= mode_d;
      bypass_q  <= bypass_d;
      col_cnt_q <= col_cnt_d;
    end
  end

  assign in_ready  = (fsm_q == IDLE) && !reset;
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign state_out = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - bench for mix_columns_seq at COLS_PER_CYCLE 1, 2 and 4 side by side
// Optional MIXCOL_BYPASS_EN exercises the bypass input.
module tb_mix_columns_seq;

  localparam logic [127:0] V1     = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V_BP   = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
  localparam logic [127:0] V_BYP  = 128'h00112233_44556677_8899aabb_ccddeeff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_valid, mode, bypass, out_ready;
  logic [127:0] state;
  logic [2:0]   in_ready, out_valid, busy;
  logic [2:0][127:0] state_out;

  int n_cmp = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mix_columns_seq #(
      .WORD_SIZE      (8),
      .ARRAY_SIZE     (16),
      .COLS_PER_CYCLE (1 << g)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready[g]),
      .mode      (mode),
`ifdef MIXCOL_BYPASS_EN
      .bypass    (bypass),
`endif
      .state     (state),
      .out_valid (out_valid[g]),
      .out_ready (out_ready),
      .state_out (state_out[g]),
      .busy      (busy[g])
    );
  end

  // Reference: carry-less product reduced by long division, then a plain matrix product.
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011B << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] mix_state(logic [127:0] s, logic inv);
    int fwd_c[4];
    int inv_c[4];
    logic [7:0] acc;
    logic [127:0] r;
    fwd_c = '{2, 3, 1, 1};
    inv_c = '{14, 11, 13, 9};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(s[(15-(4*c+j))*8 +: 8],
                           8'(inv ? inv_c[(j-row+4)%4] : fwd_c[(j-row+4)%4]));
        end
        r[(15-(4*c+row))*8 +: 8] = acc;
      end
    end
    return r;
  endfunction

  // Transaction-level model per instance: 0 idle, 1 mixing, 2 holding a result.
  int           m_st  [3] = '{0, 0, 0};
  int           m_cnt [3] = '{0, 0, 0};
  logic [127:0] m_res [3];

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (reset) begin
        m_st[g] <= 0;
      end else begin
        case (m_st[g])
          0: if (in_valid) begin
            m_st[g]  <= 1;
            m_cnt[g] <= 4 / (1 << g);
            m_res[g] <= bypass ? state : mix_state(state, mode);
          end
          1: begin
            m_cnt[g] <= m_cnt[g] - 1;
            if (m_cnt[g] == 1) m_st[g] <= 2;
          end
          default: if (out_ready) m_st[g] <= 0;
        endcase
      end
    end
  end

  logic [127:0] last_out [3];
  int           lat [3];

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic compare_all();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("in_ready[%0d]", g), 128'(in_ready[g]), 128'(m_st[g] == 0 && !reset));
      chk($sformatf("out_valid[%0d]", g), 128'(out_valid[g]), 128'(m_st[g] == 2));
      chk($sformatf("busy[%0d]", g), 128'(busy[g]), 128'(m_st[g] != 0));
      if (m_st[g] == 2) chk($sformatf("state_out[%0d]", g), state_out[g], m_res[g]);
      if (out_valid[g]) last_out[g] = state_out[g];
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(logic [127:0] st, logic md, logic bp);
    int k;
    for (k = 0; k < 40 && !(&in_ready); k++) cyc();
    if (!(&in_ready)) chk("accept_timeout", 128'(in_ready), 128'h7);
    for (int g = 0; g < 3; g++) begin
      last_out[g] = '0;
      lat[g] = 0;
    end
    in_valid = 1'b1;
    state    = st;
    mode     = md;
    bypass   = bp;
    cyc();
    in_valid = 1'b0;
    state    = {$urandom, $urandom, $urandom, $urandom};
    mode     = ~md;
    bypass   = 1'b0;
  endtask

  task automatic finish_all();
    int k;
    for (k = 1; k <= 40 && !(&in_ready && &last_out[0] !== 1'bx); k++) begin
      cyc();
      for (int g = 0; g < 3; g++) if (out_valid[g] && lat[g] == 0) lat[g] = k;
      if (&in_ready) break;
    end
    if (!(&in_ready)) chk("finish_timeout", 128'(in_ready), 128'h7);
  endtask

  initial begin
    logic [127:0] x, y;
    reset = 1'b1; in_valid = 1'b0; mode = 1'b0; bypass = 1'b0; out_ready = 1'b1;
    state = '0;
    for (int g = 0; g < 3; g++) begin
      last_out[g] = '0;
      lat[g] = 0;
    end

    chk("gmul_57_83", 128'(gmul(8'h57, 8'h83)), 128'hc1);
    chk("model_fwd", mix_state(V1, 1'b0), V1_OUT);
    chk("model_inv", mix_state(V1_OUT, 1'b1), V1);
    chk("model_bp", mix_state(V_BP, 1'b0), 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6);

    cyc();
    cyc();
    chk("reset_in_ready", 128'(in_ready), 128'h0);
    reset = 1'b0;
    #1;
    chk("post_reset_in_ready", 128'(in_ready), 128'h7);
    chk("post_reset_out_valid", 128'(out_valid), 128'h0);
    chk("post_reset_busy", 128'(busy), 128'h0);
    chk("post_reset_state_out", state_out[0] | state_out[1] | state_out[2], 128'h0);

    send(V1, 1'b0, 1'b0);
    finish_all();
    chk("fwd_result_c1", last_out[0], V1_OUT);
    chk("fwd_latency_c1", 128'(lat[0]), 128'd4);
    chk("fwd_latency_c2", 128'(lat[1]), 128'd2);
    chk("fwd_latency_c4", 128'(lat[2]), 128'd1);

    send(V1_OUT, 1'b1, 1'b0);
    finish_all();
    chk("inv_result_c4", last_out[2], V1);
    chk("inv_latency_c4", 128'(lat[2]), 128'd1);

    out_ready = 1'b0;
    send(V_BP, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) cyc();
    chk("bp_valid_all", 128'(out_valid), 128'h7);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      state    = {$urandom, $urandom, $urandom, $urandom};
      cyc();
      chk("bp_cols_c1", 128'(state_out[0][127:64]), 128'hd5d5d7d6_4d7ebdf8);
      chk("bp_in_ready", 128'(in_ready), 128'h0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    finish_all();
    chk("bp_result_c2", last_out[1], 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6);

    send(V1, 1'b0, 1'b0);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("midrun_out_valid_c1", 128'(out_valid[0]), 128'h0);
    chk("midrun_busy_c1", 128'(busy[0]), 128'h0);
    chk("midrun_in_ready_c1", 128'(in_ready[0]), 128'h1);
    chk("midrun_state_out_c1", state_out[0], 128'h0);
    for (int k = 0; k < 6; k++) cyc();
    send(V1, 1'b0, 1'b0);
    finish_all();
    chk("after_reset_c1", last_out[0], V1_OUT);

    for (int t = 0; t < 100; t++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      send(x, 1'b0, 1'b0);
      finish_all();
      y = last_out[0];
      send(y, 1'b1, 1'b0);
      finish_all();
      for (int g = 0; g < 3; g++) chk($sformatf("roundtrip[%0d]", g), last_out[g], x);
    end

`ifdef MIXCOL_BYPASS_EN
    send(V_BYP, 1'b0, 1'b1);
    finish_all();
    for (int g = 0; g < 3; g++) chk($sformatf("bypass[%0d]", g), last_out[g], V_BYP);
    chk("bypass_latency_c1", 128'(lat[0]), 128'd4);
    chk("bypass_latency_c4", 128'(lat[2]), 128'd1);
`endif

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
Sequential, parametrised MixColumns engine. Performs both the forward MixColumns and the InverseMixColumns transforms on one 128-bit AES state. It processes COLS_PER_CYCLE columns per clock and uses a valid/ready handshake on both input and output. It sits between the SubBytes/ShiftRows stage and AddRoundKey in the round datapath, in both the encrypt and decrypt paths.

Parameters:
WORD_SIZE, 8, bits per state byte; only 8 is legal.
ARRAY_SIZE, 16, bytes per state; only 16 is legal.
COLS_PER_CYCLE, 1, columns mixed per clock; legal values are 1, 2 and 4, and any other value is an elaboration error.

Ports:
clk  in  1  clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  input state and mode are valid.
in_ready  out  1  block can accept a new state.
mode  in  1  0 = forward MixColumns, 1 = InverseMixColumns; sampled on accept.
state  in  WORD_SIZE*ARRAY_SIZE  input state.
out_valid  out  1  state_out holds a finished result.
out_ready  in  1  downstream consumes the result.
state_out  out  WORD_SIZE*ARRAY_SIZE  mixed state.
busy  out  1  high in RUN or DONE.

Behaviour:
- Byte mapping: byte index b is state[(15-b)*8 +: 8]. Column c holds bytes 4c..4c+3. Row r of column c is byte 4c+r, so row 0 is the most significant byte of that column.
- Forward matrix rows: {02,03,01,01}, rotated right one position per row. Inverse matrix rows: {0E,0B,0D,09}, rotated the same way.
- Arithmetic: GF(2^8) with polynomial 0x11B. xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1B : 8'h00). 09, 0B, 0D and 0E are built from xtime chains and XOR. No wide intermediate products and no separate modulo step.
- FSM states are IDLE, RUN and DONE.
  - IDLE: in_ready=1. A transfer happens when in_valid && in_ready. On transfer, latch state into the working register, latch mode, clear col_cnt, go to RUN.
  - RUN: each cycle, replace columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 in place with their mixed values, then add COLS_PER_CYCLE to col_cnt. After the cycle that mixes column 3, go to DONE.
  - DONE: out_valid=1 and state_out is the working register. Stay in DONE while out_ready=0. When out_ready=1, go to IDLE.
- Latency: accept at edge N; out_valid is high after edge N + 4/COLS_PER_CYCLE (4, 2 or 1 RUN cycles).
- in_ready is low in RUN and DONE. in_valid is ignored there, and state/mode changes after accept have no effect.
- state_out and out_valid stay stable while stalled in DONE.
- No overlap: after the out_ready handshake there is one IDLE cycle before the next accept, giving a throughput of one state per 4/COLS_PER_CYCLE + 2 cycles.
- Reset values: in_ready=0 during reset and 1 afterwards; out_valid=0; busy=0; state_out=0; col_cnt=0; FSM=IDLE.
- Reset mid-operation: any in-flight state is discarded. Back in IDLE the next cycle, with no out_valid pulse.
- col_cnt is 2 bits wide and never wraps mid-state, because the FSM leaves RUN exactly at column 3.

Optional Feature:
MIXCOL_BYPASS_EN.
- Defined: adds input port `bypass` (1 bit), sampled on accept alongside mode. When bypass=1, the columns are copied unchanged while the FSM still runs through RUN and DONE with identical latency and handshake. This serves the final AES round, which skips MixColumns.
- Undefined: no bypass port and no bypass logic; every accepted state is mixed.

Decomposition:
- Shared package aes_pkg holds:
  - WORD_SIZE and ARRAY_SIZE constants.
  - the polynomial constant 8'h1B.
  - the FSM state typedef {IDLE, RUN, DONE}.
  - the mode encodings MC_FWD=0 and MC_INV=1.
  - the xtime function.
- One combinational sub-module, mix_column_unit: a 32-bit column in, mode in, 32-bit mixed column out. It is instantiated COLS_PER_CYCLE times, and the muxing selects which columns each instance sees.

Test Plan:
- Forward, COLS_PER_CYCLE=1. state=db135345_f20a225c_01010101_c6c6c6c6, mode=0 -> state_out=8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid exactly 4 cycles after accept.
- Inverse, COLS_PER_CYCLE=4. state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, mode=1 -> state_out=db135345_f20a225c_01010101_c6c6c6c6, with out_valid 1 cycle after accept.
- Backpressure. Hold out_ready=0 for 5 cycles in DONE with input d4d4d4d5_2d26314c_… mode=0 -> first column d5d5d7d6 and second column 4d7ebdf8; state_out stays stable, in_ready stays 0, and in_valid with new data is ignored.
- Reset mid-RUN. Assert reset on the 2nd RUN cycle -> next cycle FSM=IDLE, out_valid=0, state_out=0, no result emitted; a following accepted state produces a correct result.
- Round trip, 100 random states. Forward then inverse -> original state returned, for COLS_PER_CYCLE=1, 2 and 4.
- With MIXCOL_BYPASS_EN defined. bypass=1 and state=00112233_44556677_8899aabb_ccddeeff -> output identical to input, with the same latency as mixing.
